// File: rtl/timebase_pkg.sv
// timebase_pkg: shared field limits and sizing helper for the timebase.
package timebase_pkg;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    function automatic int hrs_w(input int hrs_max);
        return (hrs_max < 1) ? 1 : $clog2(hrs_max + 1);
    endfunction
endpackage

// File: rtl/timebase_prescaler.sv
// timebase_prescaler: half-second divider with a phase bit marking whole seconds.
module timebase_prescaler
    import timebase_pkg::*;
#(
    parameter int CLK_DIV = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic clr,
    output logic tick,
    output logic sec_tick
);
    localparam int DIV_W = $clog2(CLK_DIV);
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    assign tick     = run && div_q == DIV_W'(CLK_DIV - 1);
    assign sec_tick = tick && phase_q;
    always_comb begin
        div_d   = (clr || tick) ? '0 : run ? div_q + DIV_W'(1) : div_q;
        phase_d = clr ? 1'b0 : phase_q ^ tick;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/timebase_gen.sv
// timebase_gen: HH:MM:SS timebase with half-second/second strobes and saturating accumulators.
// Define TIMEBASE_ALARM_EN to add the alarm_time input and alarm_pulse strobe.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter  int CLK_DIV = 1024,
    parameter  int HRS_MAX = 99,
    parameter  int ACCUM_W = 13,
    localparam int HRS_W   = hrs_w(HRS_MAX),
    localparam int HMS_W   = HRS_W + MIN_W + SEC_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               load,
    input  logic [HMS_W-1:0]   load_time,
    input  logic               acc_clr,
`ifdef TIMEBASE_ALARM_EN
    input  logic [HMS_W-1:0]   alarm_time,
    output logic               alarm_pulse,
`endif
    output logic [HMS_W-1:0]   HMS_time,
    output logic [ACCUM_W-1:0] sec_accum,
    output logic [ACCUM_W-1:0] min_accum,
    output logic               half_sec_pulse,
    output logic               sec_pulse,
    output logic               rollover_pulse,
    output logic               load_err
);
    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } hms_t;
    hms_t               hms_q, hms_d, ld;
    logic [ACCUM_W-1:0] sacc_q, sacc_d, macc_q, macc_d;
    logic               half_q, sec_q, roll_q, lerr_q;
    logic               tick, sec_tick, ld_ok, ld_go, st, s_wrap, m_wrap, h_wrap, carry_m, carry_h;
    assign ld    = hms_t'(load_time);
    assign ld_ok = ld.sec <= SEC_W'(SEC_MAX) && ld.min <= MIN_W'(MIN_MAX) && ld.hrs <= HRS_W'(HRS_MAX);
    assign ld_go = load && ld_ok;
    timebase_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .clr      (ld_go),
        .tick     (tick),
        .sec_tick (sec_tick)
    );
    // A valid load swallows any tick landing in the same cycle.
    always_comb begin
        st      = sec_tick && !ld_go;
        s_wrap  = hms_q.sec == SEC_W'(SEC_MAX);
        m_wrap  = hms_q.min == MIN_W'(MIN_MAX);
        h_wrap  = hms_q.hrs == HRS_W'(HRS_MAX);
        carry_m = st && s_wrap;
        carry_h = carry_m && m_wrap;
        hms_d.sec = ld_go ? ld.sec : !st ? hms_q.sec : s_wrap ? '0 : hms_q.sec + SEC_W'(1);
        hms_d.min = ld_go ? ld.min : !carry_m ? hms_q.min : m_wrap ? '0 : hms_q.min + MIN_W'(1);
        hms_d.hrs = ld_go ? ld.hrs : !carry_h ? hms_q.hrs : h_wrap ? '0 : hms_q.hrs + HRS_W'(1);
        sacc_d = acc_clr ? '0 : (st && sacc_q != '1) ? sacc_q + ACCUM_W'(1) : sacc_q;
        macc_d = acc_clr ? '0 : (carry_m && macc_q != '1) ? macc_q + ACCUM_W'(1) : macc_q;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hms_q  <= '0;
            sacc_q <= '0;
            macc_q <= '0;
            half_q <= 1'b0;
            sec_q  <= 1'b0;
            roll_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            hms_q  <= hms_d;
            sacc_q <= sacc_d;
            macc_q <= macc_d;
            half_q <= tick && !ld_go;
            sec_q  <= st;
            roll_q <= carry_h && h_wrap;
            lerr_q <= load && !ld_ok;
        end
    end
`ifdef TIMEBASE_ALARM_EN
    logic alarm_q;
    always_ff @(posedge clock) begin
        if (!reset_n) alarm_q <= 1'b0;
        else alarm_q <= st && hms_d == hms_t'(alarm_time);
    end
    assign alarm_pulse = alarm_q;
`endif
    assign HMS_time       = hms_q;
    assign sec_accum      = sacc_q;
    assign min_accum      = macc_q;
    assign half_sec_pulse = half_q;
    assign sec_pulse      = sec_q;
    assign rollover_pulse = roll_q;
    assign load_err       = lerr_q;
endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: scoreboard bench; a seconds-count reference model queues expected outputs per cycle.
module tb_timebase_gen;
    localparam int CLK_DIV = 4;
    localparam int HRS_MAX = 2;
    localparam int ACCUM_W = 4;
    localparam int HRS_W   = $clog2(HRS_MAX + 1);
    localparam int HMS_W   = HRS_W + 12;
    localparam int ACC_MAX = (1 << ACCUM_W) - 1;

    logic clock = 1'b0;
    logic reset_n, run, load, acc_clr;
    logic [HMS_W-1:0]   load_time, alarm_time, HMS_time;
    logic [ACCUM_W-1:0] sec_accum, min_accum;
    logic half_sec_pulse, sec_pulse, rollover_pulse, load_err, alarm_pulse;

    timebase_gen #(.CLK_DIV(CLK_DIV), .HRS_MAX(HRS_MAX), .ACCUM_W(ACCUM_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .run            (run),
        .load           (load),
        .load_time      (load_time),
        .acc_clr        (acc_clr),
`ifdef TIMEBASE_ALARM_EN
        .alarm_time     (alarm_time),
        .alarm_pulse    (alarm_pulse),
`endif
        .HMS_time       (HMS_time),
        .sec_accum      (sec_accum),
        .min_accum      (min_accum),
        .half_sec_pulse (half_sec_pulse),
        .sec_pulse      (sec_pulse),
        .rollover_pulse (rollover_pulse),
        .load_err       (load_err)
    );
`ifndef TIMEBASE_ALARM_EN
    assign alarm_pulse = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [HMS_W-1:0] hms;
        int sa, ma;
        bit half, sec, roll, err, alm;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int n_chk = 0, n_err = 0;
    int m_div, m_ph, m_h, m_m, m_s, m_sa, m_ma;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [HMS_W-1:0] hms(input int h, input int m, input int s);
        return {HRS_W'(h), 6'(m), 6'(s)};
    endfunction

    // Reference model: time held as h/m/s, advanced through a total-seconds count.
    task automatic model_step();
        exp_t x;
        int lh, lm, ls, t;
        bit tk, ok, alm_en;
        lh = int'(load_time[HMS_W-1:12]);
        lm = int'(load_time[11:6]);
        ls = int'(load_time[5:0]);
        x.half = 0; x.sec = 0; x.roll = 0; x.err = 0; x.alm = 0;
`ifdef TIMEBASE_ALARM_EN
        alm_en = 1;
`else
        alm_en = 0;
`endif
        if (!reset_n) begin
            m_div = 0; m_ph = 0; m_h = 0; m_m = 0; m_s = 0; m_sa = 0; m_ma = 0;
        end else begin
            tk = run && m_div == CLK_DIV - 1;
            ok = ls < 60 && lm < 60 && lh <= HRS_MAX;
            x.err = load && !ok;
            if (load && ok) begin
                m_h = lh; m_m = lm; m_s = ls; m_div = 0; m_ph = 0;
                if (acc_clr) begin m_sa = 0; m_ma = 0; end
            end else begin
                if (tk) begin
                    m_div = 0;
                    x.half = 1;
                    if (m_ph == 1) begin
                        x.sec = 1;
                        if (acc_clr) begin
                            m_sa = 0; m_ma = 0;
                        end else begin
                            if (m_sa < ACC_MAX) m_sa++;
                            if (m_s == 59 && m_ma < ACC_MAX) m_ma++;
                        end
                        t = m_h * 3600 + m_m * 60 + m_s + 1;
                        if (t >= (HRS_MAX + 1) * 3600) begin t = 0; x.roll = 1; end
                        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                        x.alm = alm_en && hms(m_h, m_m, m_s) == alarm_time;
                    end else if (acc_clr) begin
                        m_sa = 0; m_ma = 0;
                    end
                    m_ph = 1 - m_ph;
                end else begin
                    if (run) m_div++;
                    if (acc_clr) begin m_sa = 0; m_ma = 0; end
                end
            end
        end
        x.hms = hms(m_h, m_m, m_s);
        x.sa = m_sa;
        x.ma = m_ma;
        q.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            model_step();
            @(posedge clock);
            #2;
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("hms", HMS_time, e.hms);
            check("sec_accum", sec_accum, e.sa);
            check("min_accum", min_accum, e.ma);
            check("half_pulse", half_sec_pulse, e.half);
            check("sec_pulse", sec_pulse, e.sec);
            check("roll_pulse", rollover_pulse, e.roll);
            check("load_err", load_err, e.err);
            check("alarm_pulse", alarm_pulse, e.alm);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; run = 1; load = 0; acc_clr = 0;
        load_time = '0;
        alarm_time = hms(0, 0, 3);
        cyc(2);
        check("rst_hms", HMS_time, 0);
        check("rst_half", half_sec_pulse, 0);
        // 1: free-running from reset
        reset_n = 1;
        cyc(8);
        check("first_sec", sec_pulse, 1);
        check("hms_1s", HMS_time, hms(0, 0, 1));
        // 2: full rollover
        load = 1; load_time = hms(2, 59, 59);
        cyc(1);
        load = 0;
        cyc(8);
        check("rollover", rollover_pulse, 1);
        check("roll_hms", HMS_time, 0);
        check("roll_macc", min_accum, 1);
        // 3: saturation and clear on a sec tick
        cyc(160);
        check("sacc_sat", sec_accum, ACC_MAX);
        cyc(7);
        acc_clr = 1;
        cyc(1);
        acc_clr = 0;
        check("clr_sacc", sec_accum, 0);
        check("clr_sec", sec_pulse, 1);
        check("clr_hms", HMS_time, hms(0, 0, 21));
        // 4: rejected loads
        cyc(3);
        load = 1; load_time = hms(1, 60, 0);
        cyc(1);
        load = 0;
        check("err_min", load_err, 1);
        check("err_hms", HMS_time, hms(0, 0, 21));
        load = 1; load_time = hms(3, 0, 0);
        cyc(1);
        load = 0;
        check("err_hrs", load_err, 1);
        // 5: pause mid-count
        cyc(2);
        run = 0;
        cyc(10);
        run = 1;
        cyc(12);
        // valid load together with acc_clr
        load = 1; acc_clr = 1; load_time = hms(1, 59, 58);
        cyc(1);
        load = 0; acc_clr = 0;
        check("ldclr_sacc", sec_accum, 0);
        cyc(20);
        // 6: reset mid-second, then alarm from a fresh start
        cyc(5);
        reset_n = 0;
        cyc(1);
        check("rst2_hms", HMS_time, 0);
        check("rst2_sacc", sec_accum, 0);
        reset_n = 1;
        cyc(24);
`ifdef TIMEBASE_ALARM_EN
        check("alarm_24", alarm_pulse, 1);
`endif
        cyc(16);
        for (int i = 0; i < 300; i++) begin
            run = $urandom_range(0, 9) != 0;
            acc_clr = $urandom_range(0, 30) == 0;
            load = $urandom_range(0, 25) == 0;
            load_time = hms($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) load_time = hms(2, 59, $urandom_range(50, 59));
            cyc(1);
        end
        load = 0; acc_clr = 0; run = 1;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
